// File: rtl/tt_sweep_pkg.sv
// Shared types and MISR constants for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    FN_XOR = 2'd0,
    FN_MAJ = 2'd1,
    FN_AND = 2'd2,
    FN_OR  = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned MISR_W = 8;
  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic              din);
    return {sig[MISR_W-2:0], (^(sig & MISR_TAPS)) ^ din};
  endfunction

endpackage

// File: rtl/truth_table_sweeper_eval.sv
// Combinational reduction-function evaluator: XOR, strict majority, AND, OR.
module logic_func_eval
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic [N_IN-1:0] i_vec,
  input  logic [1:0]      i_func,
  output logic            o_res
);

  localparam int unsigned PC_W = $clog2(N_IN + 1);

  logic [PC_W-1:0] w_pc;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      w_pc = w_pc + PC_W'(i_vec[i]);
    end
  end

  // Majority is strict, so an even-width tie evaluates to 0.
  always_comb begin
    o_res = 1'b0;
    case (func_e'(i_func))
      FN_XOR:  o_res = ^i_vec;
      FN_MAJ:  o_res = (w_pc > PC_W'(N_IN / 2));
      FN_AND:  o_res = &i_vec;
      FN_OR:   o_res = |i_vec;
      default: o_res = 1'b0;
    endcase
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every N_IN-bit vector, streams {vector, f(vector)} pairs and counts ones.
// Optional result signature MISR is enabled by defining TT_SWEEP_SIG_EN.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       func_sel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N_IN-1:0]  vec_out,
  output logic             res_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [7:0]       sig_out
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e           r_state;
  state_e           w_state_nxt;
  func_e            r_func;
  func_e            w_func_nxt;
  logic [N_IN-1:0]  w_vec_nxt;
  logic             w_valid_nxt;
  logic             w_res_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_ones_nxt;
  logic             w_res_eval;
  logic [1:0]       w_eval_func;
  logic             w_start_acc;
  logic             w_hs;
  logic             w_last;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_hs        = (r_state == S_RUN) && out_valid && out_ready;
  assign w_last      = (vec_out == VEC_LAST);
  // The function is evaluated on the vector about to be registered.
  assign w_eval_func = w_start_acc ? func_sel : 2'(r_func);

  logic_func_eval #(.N_IN(N_IN)) u_eval (
    .i_vec  (w_vec_nxt),
    .i_func (w_eval_func),
    .o_res  (w_res_eval)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_func_nxt  = r_func;
    w_vec_nxt   = vec_out;
    w_valid_nxt = out_valid;
    w_res_nxt   = res_out;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    w_ones_nxt  = ones_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_func_nxt  = func_e'(func_sel);
          w_vec_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_res_nxt   = w_res_eval;
          w_busy_nxt  = 1'b1;
          w_ones_nxt  = '0;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          w_ones_nxt = ones_cnt + CNT_W'(res_out);
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_vec_nxt = vec_out + N_IN'(1);
            w_res_nxt = w_res_eval;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_func    <= FN_XOR;
      out_valid <= 1'b0;
      vec_out   <= '0;
      res_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ones_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_func    <= w_func_nxt;
      out_valid <= w_valid_nxt;
      vec_out   <= w_vec_nxt;
      res_out   <= w_res_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      ones_cnt  <= w_ones_nxt;
    end
  end

`ifdef TT_SWEEP_SIG_EN
  logic [MISR_W-1:0] r_sig;

  // Signature is seeded on start and folds in each accepted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else if (w_start_acc) begin
      r_sig <= '0;
    end else if (w_hs) begin
      r_sig <= misr_step(r_sig, res_out);
    end
  end

  assign sig_out = r_sig;
`else
  assign sig_out = 8'h00;
`endif

endmodule
